// File: rtl/cf_truth_scanner_if.sv
// Interface bundle for cf_truth_scanner.
// The master side drives start and the function-under-test output y_in.
// The slave side (the scanner) drives the vector and the scan results.
interface cf_truth_scanner_if;
  logic        start;
  logic        y_in;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic [15:0] truth_table;
  logic [4:0]  err_cnt;
  logic        err_valid;
  logic [3:0]  first_err_idx;
  logic        pass;

  modport master (
    output start, y_in,
    input  abcd, busy, done, truth_table, err_cnt, err_valid, first_err_idx, pass
  );

  modport slave (
    input  start, y_in,
    output abcd, busy, done, truth_table, err_cnt, err_valid, first_err_idx, pass
  );
endinterface

// File: rtl/cf_truth_scanner.sv
// cf_truth_scanner: steps a 4-input function through all 16 input vectors,
// samples its output after SETTLE extra cycles per vector, builds the truth
// table and compares it against EXPECTED.
// Optional feature macro: CF_SCAN_STOP_ON_ERR_EN -- when defined the scan ends
// on the first mismatching sample instead of covering all 16 vectors.
module cf_truth_scanner #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = 16'hA7FF
) (
  input logic               clk,
  input logic               rst_n,
  cf_truth_scanner_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [3:0]  abcd_q, abcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  err_cnt_q, err_cnt_d;
  logic        err_valid_q, err_valid_d;
  logic [3:0]  first_q, first_d;
  logic        pass_q, pass_d;
  logic        mismatch;

  // State and result registers; reset returns everything to idle/zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      abcd_q      <= '0;
      cnt_q       <= '0;
      tt_q        <= '0;
      err_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      first_q     <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      abcd_q      <= abcd_d;
      cnt_q       <= cnt_d;
      tt_q        <= tt_d;
      err_cnt_q   <= err_cnt_d;
      err_valid_q <= err_valid_d;
      first_q     <= first_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state logic: accept start, count settle cycles, sample and compare.
  always_comb begin
    state_d     = state_q;
    abcd_d      = abcd_q;
    cnt_d       = cnt_q;
    tt_d        = tt_q;
    err_cnt_d   = err_cnt_q;
    err_valid_d = err_valid_q;
    first_d     = first_q;
    pass_d      = pass_q;
    mismatch    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          abcd_d      = '0;
          cnt_d       = SETTLE_L;
          tt_d        = '0;
          err_cnt_d   = '0;
          err_valid_d = 1'b0;
          first_d     = '0;
          pass_d      = 1'b0;
        end
      end

      ST_RUN: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          tt_d[abcd_q] = bus.y_in;
          mismatch     = (bus.y_in != EXPECTED[abcd_q]);
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 5'd1;
            if (!err_valid_q) begin
              err_valid_d = 1'b1;
              first_d     = abcd_q;
            end
          end
`ifdef CF_SCAN_STOP_ON_ERR_EN
          if (mismatch || abcd_q == 4'd15) begin
`else
          if (abcd_q == 4'd15) begin
`endif
            state_d = ST_DONE;
          end else begin
            abcd_d = abcd_q + 4'd1;
            cnt_d  = SETTLE_L;
          end
        end
      end

      ST_DONE: begin
        pass_d  = (err_cnt_q == 5'd0);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded straight from the registered state.
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.done          = (state_q == ST_DONE);
  assign bus.abcd          = abcd_q;
  assign bus.truth_table   = tt_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.err_valid     = err_valid_q;
  assign bus.first_err_idx = first_q;
  assign bus.pass          = pass_q;

endmodule

// File: tb/tb_cf_truth_scanner.sv
// Self-checking bench for cf_truth_scanner: random and directed functions are
// presented as truth tables; expected results come from a table-level model.
module tb_cf_truth_scanner;
  localparam int unsigned S   = 1;
  localparam logic [15:0] EXP = 16'hA7FF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] func_tt = 16'h0000;
  int n_checks = 0;
  int n_errors = 0;

  cf_truth_scanner_if bus ();

  cf_truth_scanner #(.SETTLE(S), .EXPECTED(EXP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Function under test modelled as a lookup table.
  assign bus.y_in = func_tt[bus.abcd];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete scan of function tt, checked cycle by cycle against the model.
  task automatic run_scan(input string name, input logic [15:0] tt, input bit hold_start);
    logic [15:0] mism, exp_tt;
    int last, first, exp_err, done_edge;
    bit stop_mode;
    bit got_done;
    mism  = tt ^ EXP;
    first = 0;
    for (int i = 15; i >= 0; i--) if (mism[i]) first = i;
`ifdef CF_SCAN_STOP_ON_ERR_EN
    stop_mode = 1'b1;
`else
    stop_mode = 1'b0;
`endif
    last = (stop_mode && mism != 16'h0) ? first : 15;
    exp_tt = '0;
    for (int i = 0; i <= last; i++) exp_tt[i] = tt[i];
    exp_err = stop_mode ? ((mism != 16'h0) ? 1 : 0) : $countones(mism);
    done_edge = (last + 1) * (S + 1);

    func_tt = tt;
    bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) bus.start = 1'b0;
    chk({name, ".busy0"}, 32'(bus.busy), 32'd1);
    chk({name, ".abcd0"}, 32'(bus.abcd), 32'd0);
    chk({name, ".pass0"}, 32'(bus.pass), 32'd0);

    for (int k = 1; k < done_edge; k++) begin
      if (!hold_start && k == 9) bus.start = 1'b1;
      @(posedge clk); #1;
      if (!hold_start && k == 10) bus.start = 1'b0;
      chk($sformatf("%s.abcd@%0d", name, k), 32'(bus.abcd), 32'(k / (S + 1)));
      chk($sformatf("%s.done@%0d", name, k), 32'(bus.done), 32'd0);
      chk($sformatf("%s.busy@%0d", name, k), 32'(bus.busy), 32'd1);
    end

    @(posedge clk); #1;
    chk({name, ".done"}, 32'(bus.done), 32'd1);
    chk({name, ".busy_done"}, 32'(bus.busy), 32'd1);
    chk({name, ".abcd_last"}, 32'(bus.abcd), 32'(last));
    chk({name, ".tt"}, 32'(bus.truth_table), 32'(exp_tt));
    chk({name, ".err_cnt"}, 32'(bus.err_cnt), 32'(exp_err));
    chk({name, ".err_valid"}, 32'(bus.err_valid), 32'(exp_err != 0));
    if (exp_err != 0) chk({name, ".first"}, 32'(bus.first_err_idx), 32'(first));

    @(posedge clk); #1;
    chk({name, ".done_off"}, 32'(bus.done), 32'd0);
    chk({name, ".busy_off"}, 32'(bus.busy), 32'd0);
    chk({name, ".pass"}, 32'(bus.pass), 32'(exp_err == 0));
    chk({name, ".tt_hold"}, 32'(bus.truth_table), 32'(exp_tt));
    chk({name, ".abcd_hold"}, 32'(bus.abcd), 32'(last));
    $display("scan %s tt=%04h: err_cnt=%0d first=%0d pass=%0d tt_out=%04h", name, tt,
             bus.err_cnt, bus.first_err_idx, bus.pass, bus.truth_table);

    if (hold_start) begin
      // Start still high: new scan must begin on the first IDLE edge.
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({name, ".restart_busy"}, 32'(bus.busy), 32'd1);
      chk({name, ".restart_pass"}, 32'(bus.pass), 32'd0);
      got_done = 1'b0;
      for (int k = 0; k < 200 && !got_done; k++) begin
        @(posedge clk); #1;
        if (bus.done) got_done = 1'b1;
      end
      chk({name, ".restart_done_seen"}, 32'(got_done), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] rtt;
    bit saw_done;
    bus.start = 1'b0;

    // Reset state.
    #1;
    chk("rst.abcd", 32'(bus.abcd), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.tt", 32'(bus.truth_table), 32'd0);
    chk("rst.err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("rst.err_valid", 32'(bus.err_valid), 32'd0);
    chk("rst.pass", 32'(bus.pass), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed functions: the correct one, constant 1, constant 0.
    run_scan("golden", EXP, 1'b0);
    run_scan("ones", 16'hFFFF, 1'b0);
    run_scan("zeros", 16'h0000, 1'b0);

    // Random functions.
    for (int r = 0; r < 4; r++) begin
      rtt = 16'($urandom);
      run_scan($sformatf("rand%0d", r), rtt, 1'b0);
    end
    // Random function differing from golden in a single random bit.
    rtt = EXP ^ (16'h1 << $urandom_range(15, 0));
    run_scan("onebit", rtt, 1'b0);

    // Start held high across completion.
    run_scan("held", EXP, 1'b1);

    // Reset mid-scan at edge 20.
    func_tt = 16'hFFFF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst.abcd", 32'(bus.abcd), 32'd0);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("midrst.tt", 32'(bus.truth_table), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("midrst.no_done", 32'(saw_done), 32'd0);
    $display("reset mid-scan: abcd=%0d busy=%0d", bus.abcd, bus.busy);
    run_scan("after_rst", EXP, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
